// File: rtl/jesd204b_tx_core_if.sv
// jesd204b_tx_core_if: user/GT-side signal bundle for the JESD204B TX link layer.
// master = user logic / SYSREF / SYNC~ source, slave = the link core.
interface jesd204b_tx_core_if #(
  parameter int DW = 32
);
  logic            i_sysref;
  logic            i_nsync;
  logic [DW-1:0]   i_tx_data;
  logic            o_tx_ready;
  logic [DW-1:0]   o_txdata;
  logic [DW/8-1:0] o_txcharisk;
  logic [1:0]      o_state;
  logic            o_lmfc_edge;

  modport master (
    output i_sysref, i_nsync, i_tx_data,
    input  o_tx_ready, o_txdata, o_txcharisk, o_state, o_lmfc_edge
  );

  modport slave (
    input  i_sysref, i_nsync, i_tx_data,
    output o_tx_ready, o_txdata, o_txcharisk, o_state, o_lmfc_edge
  );
endinterface

// File: rtl/jesd204b_tx_core.sv
// jesd204b_tx_core: JESD204B single-lane transmit link layer.
// Emits CGS (K28.5), the 4-multiframe ILAS, then user data, aligned to an LMFC
// that SYSREF rising edges re-phase. SYNC~ is double-synchronised; a low run of
// 4+ clocks drops the link back to CGS.
// Optional build macro: JESD204B_TX_CHAR_REPLACE_EN enables DATA-phase character
// replacement of repeated frame-end octets (/F/ = FC, /A/ = 7C at multiframe end).
//
// state | meaning
// ------+--------------------------------------------------------------
// CGS   | all octets K28.5; leave at an LMFC boundary once SYNC~ is high
// ILAS  | four multiframes /R/ .. /A/, /Q/ + link config in multiframe 1
// DATA  | user octets forwarded, o_tx_ready=1
module jesd204b_tx_core #(
  parameter int             USERDATA_WIDTH    = 32,
  parameter int             JESD204B_CONFIG_F = 1,
  parameter int             JESD204B_CONFIG_K = 32,
  parameter int             LMFC_CNT_WIDTH    = 8,
  parameter logic [111:0]   ILAS_CFG          = 112'h0
) (
  input logic               i_dclk,
  input logic               i_rst_n,
  jesd204b_tx_core_if.slave bus
);
  localparam int F     = JESD204B_CONFIG_F;
  localparam int K     = JESD204B_CONFIG_K;
  localparam int LANES = USERDATA_WIDTH / 8;
  localparam int FK    = F * K;
  localparam int MFC   = FK / LANES;
  localparam logic [LMFC_CNT_WIDTH-1:0] CNT_LAST = LMFC_CNT_WIDTH'(MFC - 1);

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic                      sysref_q;
  logic                      sysref_q2;
  logic                      sysref_edge;
  logic                      nsync_m;
  logic                      nsync_s;
  logic [LMFC_CNT_WIDTH-1:0] lmfc_cnt;
  logic                      cnt_last;
  logic [2:0]                low_cnt;
  logic                      sync_lost;
  state_t                    st;
  state_t                    st_eff;
  state_t                    st_nxt;
  logic [1:0]                mf;
  logic [1:0]                mf_eff;
  logic [1:0]                mf_nxt;
  logic [USERDATA_WIDTH-1:0] word_d;
  logic [LANES-1:0]          kflag_d;
  int                        oi;
`ifdef JESD204B_TX_CHAR_REPLACE_EN
  logic [7:0]                prev_last;
  logic                      prev_valid;
  logic [7:0]                ref_oct;
  logic                      ref_ok;
  int                        ref_lane;
`endif

  assign sysref_edge = sysref_q & ~sysref_q2;
  assign cnt_last    = (lmfc_cnt == CNT_LAST);
  // Four consecutive low samples, counting this one.
  assign sync_lost   = ~nsync_s & (low_cnt >= 3'd3);
  assign bus.o_state = st;

  // SYSREF sampling and SYNC~ double synchroniser.
  always_ff @(posedge i_dclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sysref_q  <= 1'b0;
      sysref_q2 <= 1'b0;
      nsync_m   <= 1'b0;
      nsync_s   <= 1'b0;
      low_cnt   <= 3'd0;
    end else begin
      sysref_q  <= bus.i_sysref;
      sysref_q2 <= sysref_q;
      nsync_m   <= bus.i_nsync;
      nsync_s   <= nsync_m;
      if (nsync_s)
        low_cnt <= 3'd0;
      else if (low_cnt != 3'd4)
        low_cnt <= low_cnt + 3'd1;
    end
  end

  // LMFC cycle counter; a SYSREF rising edge restarts the multiframe.
  always_ff @(posedge i_dclk or negedge i_rst_n) begin
    if (!i_rst_n)
      lmfc_cnt <= '0;
    else if (sysref_edge || cnt_last)
      lmfc_cnt <= '0;
    else
      lmfc_cnt <= lmfc_cnt + LMFC_CNT_WIDTH'(1);
  end

  // State this cycle's octets belong to (entry/exit take effect on the same word)
  // and the state/multiframe index to carry into the next cycle.
  always_comb begin
    st_eff = st;
    mf_eff = mf;
    if (st != ST_CGS && sync_lost) begin
      st_eff = ST_CGS;
    end else if (st == ST_CGS && nsync_s && lmfc_cnt == '0) begin
      st_eff = ST_ILAS;
      mf_eff = 2'd0;
    end
    st_nxt = st_eff;
    mf_nxt = mf_eff;
    if (st_eff == ST_ILAS && cnt_last) begin
      if (mf_eff == 2'd3) begin
        st_nxt = ST_DATA;
        mf_nxt = 2'd0;
      end else begin
        mf_nxt = mf_eff + 2'd1;
      end
    end
  end

  // Octet generation for CGS / ILAS / DATA, one lane at a time.
  always_comb begin
    word_d  = '0;
    kflag_d = '0;
    oi      = 0;
`ifdef JESD204B_TX_CHAR_REPLACE_EN
    ref_oct  = 8'h00;
    ref_ok   = 1'b0;
    ref_lane = 0;
`endif
    for (int l = 0; l < LANES; l++) begin
      oi = LANES * int'(lmfc_cnt) + l;
      case (st_eff)
        ST_ILAS: begin
          if (oi == 0) begin
            word_d[8*l +: 8] = 8'h1C;
            kflag_d[l]       = 1'b1;
          end else if (oi == FK - 1) begin
            word_d[8*l +: 8] = 8'h7C;
            kflag_d[l]       = 1'b1;
          end else if (mf_eff == 2'd1 && oi == 1) begin
            word_d[8*l +: 8] = 8'h9C;
            kflag_d[l]       = 1'b1;
          end else if (mf_eff == 2'd1 && oi >= 2 && oi <= 15) begin
            word_d[8*l +: 8] = ILAS_CFG[8*(oi-2) +: 8];
          end else begin
            word_d[8*l +: 8] = oi[7:0];
          end
        end
        ST_DATA: begin
          word_d[8*l +: 8] = bus.i_tx_data[8*l +: 8];
`ifdef JESD204B_TX_CHAR_REPLACE_EN
          // Frame-end octet: compare with the previous frame's end octet, which
          // is in this word unless the frame starts at lane 0.
          if ((l % F) == F - 1) begin
            if (l >= F) begin
              ref_lane = l - F;
              ref_oct  = bus.i_tx_data[8*ref_lane +: 8];
              ref_ok   = 1'b1;
            end else begin
              ref_oct  = prev_last;
              ref_ok   = prev_valid;
            end
            if (ref_ok && ref_oct == bus.i_tx_data[8*l +: 8]) begin
              word_d[8*l +: 8] = (oi == FK - 1) ? 8'h7C : 8'hFC;
              kflag_d[l]       = 1'b1;
            end
          end
`endif
        end
        default: begin
          word_d[8*l +: 8] = 8'hBC;
          kflag_d[l]       = 1'b1;
        end
      endcase
    end
  end

  // Link FSM state and registered GT-facing outputs.
  always_ff @(posedge i_dclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st              <= ST_CGS;
      mf              <= 2'd0;
      bus.o_txdata    <= {LANES{8'hBC}};
      bus.o_txcharisk <= '1;
      bus.o_tx_ready  <= 1'b0;
      bus.o_lmfc_edge <= 1'b0;
`ifdef JESD204B_TX_CHAR_REPLACE_EN
      prev_last       <= 8'h00;
      prev_valid      <= 1'b0;
`endif
    end else begin
      st              <= st_nxt;
      mf              <= mf_nxt;
      bus.o_txdata    <= word_d;
      bus.o_txcharisk <= kflag_d;
      bus.o_tx_ready  <= (st_nxt == ST_DATA);
      bus.o_lmfc_edge <= (lmfc_cnt == '0);
`ifdef JESD204B_TX_CHAR_REPLACE_EN
      prev_last       <= bus.i_tx_data[USERDATA_WIDTH-1 -: 8];
      prev_valid      <= (st_eff == ST_DATA);
`endif
    end
  end
endmodule

// File: tb/tb_jesd204b_tx_core.sv
// tb_jesd204b_tx_core: randomized bench with an in-bench link-layer reference model
// plus literal spot checks of CGS, ILAS content, sync loss, SYSREF re-phase and
// DATA-phase character replacement (when JESD204B_TX_CHAR_REPLACE_EN is defined).
module tb_jesd204b_tx_core;
  localparam int F   = 1;
  localparam int K   = 32;
  localparam int FK  = F * K;
  localparam int MFC = FK / 4;
  localparam logic [111:0] CFG = 112'hADACABAAA9A8A7A6A5A4A3A2A1A0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  jesd204b_tx_core_if bus ();

  jesd204b_tx_core #(
    .USERDATA_WIDTH   (32),
    .JESD204B_CONFIG_F(F),
    .JESD204B_CONFIG_K(K),
    .LMFC_CNT_WIDTH   (8),
    .ILAS_CFG         (CFG)
  ) dut (
    .i_dclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit rand_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  exp_data;
  logic [3:0]   exp_k;
  logic [1:0]   exp_state;
  logic         exp_ready;
  logic         exp_edge;
  int           m_cnt;
  int           m_phase;   // 0 CGS, 1 ILAS, 2 DATA
  int           m_mf;
  bit           sr1, sr2;
  bit           ns_hist[$];
  logic [111:0] cfg_v = CFG;
`ifdef JESD204B_TX_CHAR_REPLACE_EN
  logic [31:0]  m_prev_word;
  bit           m_prev_ok;
`endif

  function automatic void ilas_octet(input int mf, input int oi, output logic [7:0] v, output logic k);
    k = 1'b0;
    if (oi == 0) begin v = 8'h1C; k = 1'b1; end
    else if (oi == FK - 1) begin v = 8'h7C; k = 1'b1; end
    else if (mf == 1 && oi == 1) begin v = 8'h9C; k = 1'b1; end
    else if (mf == 1 && oi >= 2 && oi <= 15) v = cfg_v[8*(oi-2) +: 8];
    else v = oi[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_data = 32'hBCBCBCBC; exp_k = 4'hF; exp_state = 2'd0; exp_ready = 1'b0; exp_edge = 1'b0;
      m_cnt = 0; m_phase = 0; m_mf = 0; sr1 = 1'b0; sr2 = 1'b0;
      ns_hist.delete();
`ifdef JESD204B_TX_CHAR_REPLACE_EN
      m_prev_word = 32'h0; m_prev_ok = 1'b0;
`endif
    end else begin
      bit ns_now, lost, sr_edge;
      int eff, emf, nxt, oi;
      logic [7:0] v;
      logic kk;
      ns_now = (ns_hist.size() > 1) ? ns_hist[1] : 1'b0;
      lost = 1'b1;
      for (int i = 1; i <= 4; i++) if (ns_hist.size() > i && ns_hist[i]) lost = 1'b0;
      sr_edge = sr1 && !sr2;
      eff = m_phase; emf = m_mf;
      if (m_phase != 0 && lost) eff = 0;
      else if (m_phase == 0 && ns_now && m_cnt == 0) begin eff = 1; emf = 0; end
      for (int l = 0; l < 4; l++) begin
        oi = 4 * m_cnt + l;
        if (eff == 1) ilas_octet(emf, oi, v, kk);
        else if (eff == 2) begin v = bus.i_tx_data[8*l +: 8]; kk = 1'b0; end
        else begin v = 8'hBC; kk = 1'b1; end
        exp_data[8*l +: 8] = v;
        exp_k[l] = kk;
      end
`ifdef JESD204B_TX_CHAR_REPLACE_EN
      if (eff == 2) begin
        logic [7:0] s [8];
        int j;
        for (int i = 0; i < 4; i++) begin
          s[i]   = m_prev_word[8*i +: 8];
          s[4+i] = bus.i_tx_data[8*i +: 8];
        end
        for (int l = 0; l < 4; l++) begin
          if ((l + 1) % F == 0) begin
            j = 4 + l - F;
            if ((j >= 4 || m_prev_ok) && s[j] == s[4+l]) begin
              exp_data[8*l +: 8] = (4 * m_cnt + l == FK - 1) ? 8'h7C : 8'hFC;
              exp_k[l] = 1'b1;
            end
          end
        end
        m_prev_word = bus.i_tx_data;
      end
      m_prev_ok = (eff == 2);
`endif
      nxt = eff;
      if (eff == 1 && m_cnt == MFC - 1) begin
        if (emf == 3) nxt = 2;
        else emf = emf + 1;
      end
      m_phase   = nxt;
      m_mf      = (nxt == 1) ? emf : 0;
      exp_state = 2'(nxt);
      exp_ready = (nxt == 2);
      exp_edge  = (m_cnt == 0);
      m_cnt     = sr_edge ? 0 : (m_cnt + 1) % MFC;
      sr2 = sr1; sr1 = bus.i_sysref;
      ns_hist.push_front(bus.i_nsync);
      if (ns_hist.size() > 8) void'(ns_hist.pop_back());
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("txdata",    bus.o_txdata, exp_data);
      check("txcharisk", 32'(bus.o_txcharisk), 32'(exp_k));
      check("state",     32'(bus.o_state), 32'(exp_state));
      check("tx_ready",  32'(bus.o_tx_ready), 32'(exp_ready));
      check("lmfc_edge", 32'(bus.o_lmfc_edge), 32'(exp_edge));
    end
  end

  // Random user data source.
  always @(negedge clk) begin
    if (rand_data) begin
      case ($urandom_range(0, 3))
        0: bus.i_tx_data = 32'h55555555;
        1: bus.i_tx_data = {4{8'($urandom_range(0, 255))}};
        2: bus.i_tx_data = {2{16'($urandom)}};
        default: bus.i_tx_data = $urandom;
      endcase
    end
  end

  // sel: 0 state==ILAS, 1 tx_ready, 2 state==CGS, 3 lmfc_edge, else state==DATA
  task automatic wait_sig(input string name, input int sel, input int max, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < max) begin
      @(negedge clk);
      cyc++;
      case (sel)
        0: hit = (bus.o_state == 2'd1);
        1: hit = bus.o_tx_ready;
        2: hit = (bus.o_state == 2'd0);
        3: hit = bus.o_lmfc_edge;
        default: hit = (bus.o_state == 2'd2);
      endcase
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL %s: event not seen within %0d cycles", name, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int burst;
    int sr_hold;
    bus.i_sysref  = 1'b0;
    bus.i_nsync   = 1'b0;
    bus.i_tx_data = 32'h0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_data = 1'b1;

    // CGS holds while SYNC~ is low
    repeat (20) @(negedge clk);
    check("cgs_data",  bus.o_txdata, 32'hBCBCBCBC);
    check("cgs_k",     32'(bus.o_txcharisk), 32'hF);
    check("cgs_state", 32'(bus.o_state), 32'd0);
    check("cgs_ready", 32'(bus.o_tx_ready), 32'd0);

    // SYSREF pulse, then SYNC~ release -> ILAS content
    bus.i_sysref = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_sysref = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_nsync = 1'b1;
    wait_sig("ilas_start", 0, 40, cyc);
    check("ilas_mf0_w0",  bus.o_txdata, 32'h0302011C);
    check("ilas_mf0_k0",  32'(bus.o_txcharisk), 32'h1);
    check("ilas_edge0",   32'(bus.o_lmfc_edge), 32'd1);
    repeat (7) @(negedge clk);
    check("ilas_mf0_w7",  bus.o_txdata, 32'h7C1E1D1C);
    check("ilas_mf0_k7",  32'(bus.o_txcharisk), 32'h8);
    @(negedge clk);
    check("ilas_mf1_w0",  bus.o_txdata, 32'hA1A09C1C);
    check("ilas_mf1_k0",  32'(bus.o_txcharisk), 32'h3);
    @(negedge clk);
    check("ilas_mf1_w1",  bus.o_txdata, 32'hA5A4A3A2);
    check("ilas_mf1_k1",  32'(bus.o_txcharisk), 32'h0);
    wait_sig("ilas_to_ready", 1, 40, cyc);
    check("ilas_len", 32'(cyc), 32'd22);
    check("data_state", 32'(bus.o_state), 32'd2);
    repeat (30) @(negedge clk);

    // Short SYNC~ glitch is ignored, 4+ clocks drops to CGS
    bus.i_nsync = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_nsync = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_state", 32'(bus.o_state), 32'd2);
    bus.i_nsync = 1'b0;
    wait_sig("loss", 2, 20, cyc);
    check("loss_latency", 32'(cyc), 32'd6);
    check("loss_data",  bus.o_txdata, 32'hBCBCBCBC);
    check("loss_ready", 32'(bus.o_tx_ready), 32'd0);
    repeat (3) @(negedge clk);
    bus.i_nsync = 1'b1;
    wait_sig("resync", 0, 40, cyc);
    check("resync_w0", bus.o_txdata, 32'h0302011C);

    // Constant 0x55 data: character replacement (or verbatim pass-through)
    rand_data = 1'b0;
    bus.i_tx_data = 32'h55555555;
    wait_sig("ready2", 1, 40, cyc);
    @(negedge clk);
`ifdef JESD204B_TX_CHAR_REPLACE_EN
    check("rep_first",  bus.o_txdata, 32'hFCFCFC55);
    check("rep_first_k", 32'(bus.o_txcharisk), 32'hE);
    @(negedge clk);
    check("rep_mid",    bus.o_txdata, 32'hFCFCFCFC);
    check("rep_mid_k",  32'(bus.o_txcharisk), 32'hF);
    repeat (6) @(negedge clk);
    check("rep_end",    bus.o_txdata, 32'h7CFCFCFC);
    check("rep_end_k",  32'(bus.o_txcharisk), 32'hF);
`else
    check("pass_first",  bus.o_txdata, 32'h55555555);
    check("pass_first_k", 32'(bus.o_txcharisk), 32'h0);
    @(negedge clk);
    check("pass_mid",    bus.o_txdata, 32'h55555555);
    repeat (6) @(negedge clk);
    check("pass_end",    bus.o_txdata, 32'h55555555);
    check("pass_end_k",  32'(bus.o_txcharisk), 32'h0);
`endif

    // SYSREF re-phase in DATA
    wait_sig("lmfc_a", 3, 20, cyc);
    bus.i_sysref = 1'b1;
    wait_sig("lmfc_b", 3, 20, cyc);
    check("sysref_rephase", 32'(cyc), 32'd3);
    check("rephase_state", 32'(bus.o_state), 32'd2);
    bus.i_sysref = 1'b0;
    wait_sig("lmfc_c", 3, 20, cyc);
    check("lmfc_period", 32'(cyc), 32'd8);

    // Randomized traffic: SYNC~ bursts, SYSREF pulses, one async reset
    rand_data = 1'b1;
    burst = 0;
    sr_hold = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 350) begin #2 rst_n = 1'b0; end
      if (i == 352) begin #2 rst_n = 1'b1; end
      if (burst > 0) begin
        bus.i_nsync = 1'b0;
        burst--;
      end else if ($urandom_range(0, 59) == 0) begin
        burst = $urandom_range(1, 6);
        bus.i_nsync = 1'b0;
        burst--;
      end else begin
        bus.i_nsync = 1'b1;
      end
      if (sr_hold > 0) begin
        sr_hold--;
        if (sr_hold == 0) bus.i_sysref = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        bus.i_sysref = 1'b1;
        sr_hold = $urandom_range(1, 3);
      end
    end

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
